// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-interface emulator: SPI mode-0 slave oversampled in the
// clk108MHz domain, serving device ID, snapshot x/y/z samples, STATUS,
// FILTER_CTL and POWER_CTL, and reporting every write byte on a strobe port.
`timescale 1ns/1ps

module adxl362_spi_responder #(
  parameter int         SYNC_STAGES = 2,      // must be >= 2
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic       clk108MHz,
  input  logic       resetPressed,
  input  logic       ACL_SCLK,
  input  logic       ACL_CSN,
  input  logic       ACL_MOSI,
  output logic       ACL_MISO,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  input  logic [7:0] z_data,
  input  logic       data_ready,
  output logic [7:0] power_ctl,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] RDATA  = 3'd3;
  localparam logic [2:0] WDATA  = 3'd4;
  localparam logic [2:0] IGNORE = 3'd5;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
  localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

  logic [SYNC_STAGES-1:0] sclkSync, csnSync, mosiSync;
  logic                   sclkPrev, csnPrev;

  logic [2:0] state;
  logic [2:0] bitCnt;
  logic [7:0] shiftIn, shiftOut, addr;
  logic       isRead;
  logic [7:0] shadowX, shadowY, shadowZ;
  logic       shadowReady;
  logic [7:0] filterCtl;

  logic       sclkRise, sclkFall, csnRise, csnFall, mosiBit, lastBit;
  logic [7:0] shiftNext;

  // Synchronizer chains plus one edge-detect flop per SPI line.
  always_ff @(posedge clk108MHz) begin
    if (resetPressed) begin
      // NOTE: the CSN chain clears to 0 so that a reset taken while CSN is
      // held low shows no falling edge; the master's remaining clocks are then
      // ignored until it deselects and selects again.
      sclkSync <= '0;
      csnSync  <= '0;
      mosiSync <= '0;
      sclkPrev <= 1'b0;
      csnPrev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous
      // stage's old value, which is what makes this a shift chain.
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], ACL_SCLK};
      csnSync  <= {csnSync[SYNC_STAGES-2:0],  ACL_CSN};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], ACL_MOSI};
      sclkPrev <= sclkSync[SYNC_STAGES-1];
      csnPrev  <= csnSync[SYNC_STAGES-1];
    end
  end

  assign sclkRise  =  sclkSync[SYNC_STAGES-1] & ~sclkPrev;
  assign sclkFall  = ~sclkSync[SYNC_STAGES-1] &  sclkPrev;
  assign csnRise   =  csnSync[SYNC_STAGES-1]  & ~csnPrev;
  assign csnFall   = ~csnSync[SYNC_STAGES-1]  &  csnPrev;
  assign mosiBit   =  mosiSync[SYNC_STAGES-1];
  assign shiftNext = {shiftIn[6:0], mosiBit};
  assign lastBit   = (bitCnt == 3'd7);

  // Read side of the register map; shadow copies keep a burst coherent.
  function automatic logic [7:0] readReg(input logic [7:0] a);
    case (a)
      8'h00:           readReg = 8'hAD;
      8'h01:           readReg = 8'h1D;
      8'h02:           readReg = PARTID;
      8'h08:           readReg = shadowX;
      8'h09:           readReg = shadowY;
      8'h0A:           readReg = shadowZ;
      8'h0B:           readReg = {7'b0, shadowReady};
      ADDR_FILTER_CTL: readReg = filterCtl;
      ADDR_POWER_CTL:  readReg = power_ctl;
      default:         readReg = 8'h00;
    endcase
  endfunction

  // Transaction FSM: CSN edges take priority over any SCLK activity.
  always_ff @(posedge clk108MHz) begin
    if (resetPressed) begin
      state       <= IDLE;
      bitCnt      <= 3'd0;
      shiftIn     <= 8'h00;
      shiftOut    <= 8'h00;
      addr        <= 8'h00;
      isRead      <= 1'b0;
      shadowX     <= 8'h00;
      shadowY     <= 8'h00;
      shadowZ     <= 8'h00;
      shadowReady <= 1'b0;
      filterCtl   <= 8'h13;
      power_ctl   <= 8'h00;
      ACL_MISO    <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      cmd_error   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      cmd_error <= 1'b0;
      if (csnRise) begin
        state    <= IDLE;
        bitCnt   <= 3'd0;
        ACL_MISO <= 1'b0;
      end else if (csnFall) begin
        shadowX     <= x_data;
        shadowY     <= y_data;
        shadowZ     <= z_data;
        shadowReady <= data_ready;
        bitCnt      <= 3'd0;
        shiftIn     <= 8'h00;
        ACL_MISO    <= 1'b0;
        state       <= CMD;
      end else begin
        case (state)
          CMD: if (sclkRise) begin
            shiftIn <= shiftNext;
            bitCnt  <= bitCnt + 3'd1;
            if (lastBit) begin
              if (shiftNext == CMD_READ) begin
                isRead <= 1'b1;
                state  <= ADDR;
              end else if (shiftNext == CMD_WRITE) begin
                isRead <= 1'b0;
                state  <= ADDR;
              end else begin
                cmd_error <= 1'b1;
                state     <= IGNORE;
              end
            end
          end
          ADDR: if (sclkRise) begin
            shiftIn <= shiftNext;
            bitCnt  <= bitCnt + 3'd1;
            if (lastBit) begin
              if (isRead) begin
                shiftOut <= readReg(shiftNext);
                addr     <= shiftNext + 8'd1;
                state    <= RDATA;
              end else begin
                addr  <= shiftNext;
                state <= WDATA;
              end
            end
          end
          RDATA: begin
            if (sclkFall) begin
              ACL_MISO <= shiftOut[7];
              shiftOut <= {shiftOut[6:0], 1'b0};
            end else if (sclkRise) begin
              bitCnt <= bitCnt + 3'd1;
              if (lastBit) begin
                shiftOut <= readReg(addr);
                addr     <= addr + 8'd1;
              end
            end
          end
          WDATA: if (sclkRise) begin
            shiftIn <= shiftNext;
            bitCnt  <= bitCnt + 3'd1;
            if (lastBit) begin
              if (addr == ADDR_FILTER_CTL) filterCtl <= shiftNext;
              if (addr == ADDR_POWER_CTL)  power_ctl <= shiftNext;
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= shiftNext;
              addr      <= addr + 8'd1;
            end
          end
          IGNORE:  ACL_MISO <= 1'b0;
          IDLE:    ACL_MISO <= 1'b0;
          default: begin
            state    <= IDLE;
            ACL_MISO <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Bench for adxl362_spi_responder: bit-banged SPI master, a directed vector
// table, hand-written corner sequences and a randomized phase checked against
// a register-image model.
`timescale 1ns/1ps

module tb_adxl362_spi_responder;

  localparam int HALF = 6;  // SCLK half period in clk108MHz cycles

  logic       clk108MHz = 1'b0;
  logic       resetPressed;
  logic       ACL_SCLK, ACL_CSN, ACL_MOSI, ACL_MISO;
  logic [7:0] x_data, y_data, z_data;
  logic       data_ready;
  logic [7:0] power_ctl, wr_addr, wr_data;
  logic       wr_strobe, cmd_error;

  always #5 clk108MHz = ~clk108MHz;

  adxl362_spi_responder dut (
    .clk108MHz    (clk108MHz),
    .resetPressed (resetPressed),
    .ACL_SCLK     (ACL_SCLK),
    .ACL_CSN      (ACL_CSN),
    .ACL_MOSI     (ACL_MOSI),
    .ACL_MISO     (ACL_MISO),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .data_ready   (data_ready),
    .power_ctl    (power_ctl),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cmd_error    (cmd_error)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitors, sampled on the falling clock edge.
  logic [15:0] strobeQ[$];
  int          errPulses      = 0;
  int          misoHighCycles = 0;
  bit          watchMiso      = 1'b0;

  always @(negedge clk108MHz) begin
    if (wr_strobe) strobeQ.push_back({wr_addr, wr_data});
    if (cmd_error) errPulses++;
    if (watchMiso && ACL_MISO) misoHighCycles++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- master
  task automatic waitClk(input int n);
    repeat (n) @(negedge clk108MHz);
  endtask

  task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      ACL_MOSI = tx[i];
      waitClk(HALF);
      rx[i]    = ACL_MISO;
      ACL_SCLK = 1'b1;
      waitClk(HALF);
      ACL_SCLK = 1'b0;
    end
  endtask

  task automatic csnLow();
    ACL_CSN = 1'b0;
    waitClk(HALF);
  endtask

  task automatic csnHigh();
    waitClk(HALF);
    ACL_CSN = 1'b1;
    waitClk(HALF + 4);
  endtask

  task automatic pulseReset();
    resetPressed = 1'b1;
    waitClk(3);
    resetPressed = 1'b0;
    waitClk(2);
  endtask

  logic [7:0] rxBuf[8];

  task automatic doRead(input logic [7:0] a, input int n);
    logic [7:0] junk;
    csnLow();
    spiBits(8'h0B, 8, junk);
    spiBits(a, 8, junk);
    for (int i = 0; i < n; i++) spiBits(8'($urandom), 8, rxBuf[i]);
    csnHigh();
  endtask

  task automatic doWrite(input logic [7:0] a, input int n, input logic [23:0] d);
    logic [7:0] junk;
    strobeQ.delete();
    csnLow();
    spiBits(8'h0A, 8, junk);
    spiBits(a, 8, junk);
    for (int i = 0; i < n; i++) spiBits(d[23-8*i -: 8], 8, junk);
    csnHigh();
    modelWrite(a, n, d);
  endtask

  // ----------------------------------------------------------------- model
  logic [7:0] mPower  = 8'h00;
  logic [7:0] mFilter = 8'h13;

  // Full 256-byte readable image as the master would see it this transaction.
  function automatic logic [7:0] modelByte(input logic [7:0] a, input logic [7:0] x,
                                           input logic [7:0] y, input logic [7:0] z,
                                           input logic dr);
    logic [7:0] img[256];
    foreach (img[i]) img[i] = 8'h00;
    img[8'h00] = 8'hAD;  img[8'h01] = 8'h1D;  img[8'h02] = 8'hF2;
    img[8'h08] = x;      img[8'h09] = y;      img[8'h0A] = z;
    img[8'h0B] = {7'b0, dr};
    img[8'h2C] = mFilter; img[8'h2D] = mPower;
    return img[a];
  endfunction

  function automatic void modelWrite(input logic [7:0] a, input int n, input logic [23:0] d);
    for (int i = 0; i < n; i++) begin
      logic [7:0] aa = 8'((int'(a) + i) % 256);
      if (aa == 8'h2C) mFilter = d[23-8*i -: 8];
      if (aa == 8'h2D) mPower  = d[23-8*i -: 8];
    end
  endfunction

  task automatic checkStrobes(input string tag, input logic [7:0] a, input int n, input logic [23:0] d);
    check($sformatf("%s strobe count", tag), strobeQ.size(), n);
    for (int i = 0; i < n && i < strobeQ.size(); i++)
      check($sformatf("%s strobe %0d addr/data", tag, i), strobeQ[i],
            {8'((int'(a) + i) % 256), d[23-8*i -: 8]});
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit         isWrite;
    logic [7:0] addr;
    int         n;
    logic [7:0] b0, b1, b2;   // write data, or expected read bytes
    logic [7:0] x, y, z;
    logic       dr;
    logic [7:0] expPower;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] r0, r1, r2, junk;
    logic [7:0] addrPool[10] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h0A, 8'h0B,
                                 8'h2C, 8'h2D, 8'hFE};
    int errBase;

    vecs[0] = '{1'b0, 8'h00, 3, 8'hAD, 8'h1D, 8'hF2, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h08, 3, 8'h3A, 8'hC5, 8'h10, 8'h3A, 8'hC5, 8'h10, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h0B, 1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 8'h2D, 1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[4] = '{1'b0, 8'h2D, 1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[5] = '{1'b0, 8'h2C, 2, 8'h13, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[6] = '{1'b0, 8'h03, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[7] = '{1'b0, 8'hFF, 2, 8'h00, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[8] = '{1'b1, 8'h2C, 1, 8'h25, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02};

    resetPressed = 1'b1;
    ACL_SCLK = 1'b0;  ACL_CSN = 1'b1;  ACL_MOSI = 1'b0;
    x_data = 8'h00;   y_data = 8'h00;  z_data = 8'h00;  data_ready = 1'b0;
    waitClk(4);
    check("reset ACL_MISO",  ACL_MISO,  0);
    check("reset power_ctl", power_ctl, 8'h00);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset wr_addr",   wr_addr,   8'h00);
    check("reset wr_data",   wr_data,   8'h00);
    check("reset cmd_error", cmd_error, 0);
    resetPressed = 1'b0;
    waitClk(4);

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      logic [7:0] expB[3];
      expB = '{vecs[v].b0, vecs[v].b1, vecs[v].b2};
      x_data = vecs[v].x;  y_data = vecs[v].y;  z_data = vecs[v].z;
      data_ready = vecs[v].dr;
      if (vecs[v].isWrite) begin
        doWrite(vecs[v].addr, vecs[v].n, {vecs[v].b0, vecs[v].b1, vecs[v].b2});
        checkStrobes($sformatf("vec%0d", v), vecs[v].addr, vecs[v].n,
                     {vecs[v].b0, vecs[v].b1, vecs[v].b2});
      end else begin
        doRead(vecs[v].addr, vecs[v].n);
        for (int i = 0; i < vecs[v].n; i++)
          check($sformatf("vec%0d read byte %0d", v, i), rxBuf[i], expB[i]);
      end
      check($sformatf("vec%0d power_ctl", v), power_ctl, vecs[v].expPower);
    end
    check("no cmd_error on valid commands", errPulses, 0);

    // Snapshot coherence: x_data changes mid-burst are not visible.
    x_data = 8'h3A;  y_data = 8'hC5;  z_data = 8'h10;
    csnLow();
    spiBits(8'h0B, 8, junk);
    spiBits(8'h08, 8, junk);
    spiBits(8'h00, 8, r0);
    x_data = 8'h77;
    spiBits(8'h00, 8, r1);
    spiBits(8'h00, 8, r2);
    csnHigh();
    check("snapshot byte0", r0, 8'h3A);
    check("snapshot byte1", r1, 8'hC5);
    check("snapshot byte2", r2, 8'h10);
    doRead(8'h08, 1);
    check("next txn sees new x", rxBuf[0], 8'h77);

    // Write burst wrapping 0xFF -> 0x00, nothing writable touched.
    pulseReset();
    mPower = 8'h00;  mFilter = 8'h13;
    doWrite(8'hFF, 2, 24'h556600);
    checkStrobes("wrap burst", 8'hFF, 2, 24'h556600);
    check("wrap burst power_ctl", power_ctl, 8'h00);
    doRead(8'h2C, 1);
    check("wrap burst FILTER_CTL", rxBuf[0], 8'h13);

    // Unsupported command: one cmd_error, MISO quiet throughout.
    errBase = errPulses;
    misoHighCycles = 0;
    watchMiso = 1'b1;
    csnLow();
    spiBits(8'h0D, 8, junk);
    check("bad cmd pulse after 8th rise", errPulses - errBase, 1);
    spiBits(8'hFF, 8, junk);
    csnHigh();
    watchMiso = 1'b0;
    check("bad cmd single pulse", errPulses - errBase, 1);
    check("bad cmd MISO stays low", misoHighCycles, 0);

    // CSN raised after 5 bits of a write data byte.
    strobeQ.delete();
    csnLow();
    spiBits(8'h0A, 8, junk);
    spiBits(8'h2D, 8, junk);
    spiBits(8'hFF, 5, junk);
    csnHigh();
    check("partial byte no strobe", strobeQ.size(), 0);
    check("partial byte power_ctl", power_ctl, 8'h00);

    // Reset in the middle of a read.
    doWrite(8'h2D, 1, 24'h080000);
    check("pre-reset power_ctl", power_ctl, 8'h08);
    csnLow();
    spiBits(8'h0B, 8, junk);
    spiBits(8'h00, 8, junk);
    waitClk(HALF);
    check("MISO carries 0xAD msb", ACL_MISO, 1);
    resetPressed = 1'b1;
    waitClk(1);
    check("MISO low right after reset", ACL_MISO, 0);
    resetPressed = 1'b0;
    check("power_ctl cleared by reset", power_ctl, 8'h00);
    mPower = 8'h00;  mFilter = 8'h13;
    misoHighCycles = 0;
    watchMiso = 1'b1;
    spiBits(8'h00, 8, junk);
    watchMiso = 1'b0;
    csnHigh();
    check("post-reset clocks ignored", misoHighCycles, 0);
    doRead(8'h01, 1);
    check("post-reset decode", rxBuf[0], 8'h1D);

    // Randomized transactions against the register-image model.
    for (int t = 0; t < 30; t++) begin
      logic [7:0]  a;
      int          n;
      logic [23:0] d;
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : addrPool[$urandom_range(0, 9)];
      n = $urandom_range(1, 3);
      d = 24'($urandom);
      x_data = 8'($urandom);  y_data = 8'($urandom);  z_data = 8'($urandom);
      data_ready = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        doWrite(a, n, d);
        checkStrobes($sformatf("rand%0d", t), a, n, d);
        check($sformatf("rand%0d power_ctl", t), power_ctl, mPower);
      end else begin
        logic [7:0] sx, sy, sz;
        logic       sdr;
        sx = x_data;  sy = y_data;  sz = z_data;  sdr = data_ready;
        doRead(a, n);
        for (int i = 0; i < n; i++)
          check($sformatf("rand%0d read addr %0h", t, 8'((int'(a) + i) % 256)), rxBuf[i],
                modelByte(8'((int'(a) + i) % 256), sx, sy, sz, sdr));
      end
    end
    check("total cmd_error pulses", errPulses, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
